controlador_elevador: RTL and testbench
=======================================

# controlador_elevador

Elevator car controller that consumes the ~0.75 Hz slow clock from the frequency divider and turns it into floor-by-floor motion. It runs entirely on the board clock. The slow clock is synchronised and edge-detected into a one-cycle `tick`, and every movement or door decision is taken on a `tick`. Floor calls are latched every board-clock cycle. The block drives the floor number, the direction lamps and the door output for the display logic downstream.

## Interface
- `N_ANDARES`, default 4: number of floors, minimum 2.
- `TEMPO_PORTA`, default 3: ticks the door stays open, minimum 1.
- `clock` input, 1 bit: board clock; the only clock in the block.
- `reset` input, 1 bit: synchronous, active-low.
- `pulso_lento` input, 1 bit: slow clock from the divider, treated as asynchronous.
- `chamadas` input, `N_ANDARES` bits: call buttons, one bit per floor, any pulse width.
- `andar_atual` output, `$clog2(N_ANDARES)` bits: current floor.
- `subindo` output, 1 bit: high while the state is SUBINDO.
- `descendo` output, 1 bit: high while the state is DESCENDO.
- `porta_aberta` output, 1 bit: high while the state is PORTA.
- `pendentes` output, `N_ANDARES` bits: latched calls not yet served.

## Operation
- **Tick generation.** `pulso_lento` passes through a 2-flop synchroniser and a third flop. `tick` = stage2 & ~stage3, giving one cycle per rising edge of `pulso_lento`.
- **Call latching.** Every cycle, `pendentes |= chamadas`.
- **Call clear.** The bit for `andar_atual` is cleared on the cycle the FSM enters PORTA. It stays masked while in PORTA: a call at the current floor during PORTA reloads the door timer to `TEMPO_PORTA` and is not latched.
- **Direction memory.** Register `ultimo_sentido` holds the last travel direction. Its reset value is "up".
- **FSM.** States are PARADO, SUBINDO, DESCENDO and PORTA. Reset state is PARADO. All transitions occur only on `tick`.
  - **PARADO:**
    - If the current floor's bit is pending, go to PORTA.
    - Otherwise, if calls are pending both above and below, follow `ultimo_sentido`.
    - Otherwise go toward whichever side has a call.
    - With no calls, stay in PARADO.
  - **SUBINDO:** `andar_atual` += 1. If the bit for the new floor is pending, go to PORTA; otherwise stay in SUBINDO. Set `ultimo_sentido` to up.
  - **DESCENDO:** mirror of SUBINDO (`andar_atual` -= 1, set `ultimo_sentido` to down).
  - **PORTA:**
    - The timer is loaded with `TEMPO_PORTA` on entry and decrements on each `tick`.
    - On the `tick` where the timer equals 1, leave PORTA.
    - Go to a direction in `ultimo_sentido` if calls remain that way, else the opposite direction if calls remain there, else PARADO.
- **Floor bounds.** `andar_atual` saturates at 0 and at `N_ANDARES-1`. Reaching a bound while moving with no call there forces PARADO; this case is unreachable in normal operation.
- **Calls to an already-pending floor** are idempotent.
- **Calls behind the car while moving** are latched and served after reversal.

## Timing
- Reset values: `andar_atual` = 0, `subindo` = 0, `descendo` = 0, `porta_aberta` = 0, `pendentes` = 0. Timer, synchroniser and `ultimo_sentido` also reset.
- Reset asserted mid-motion or with the door open aborts immediately on the next clock edge. All pending calls are lost.
- The `pendentes` bit is visible one cycle after a `chamadas` bit rises.
- `pulso_lento` rising to state update: the update lands on the 3rd rising `clock` edge after the input rises.
- All outputs are registered or decoded from registered state. No combinational path exists from inputs to outputs.
- A `chamadas` bit and `tick` on the same cycle: the call is not yet visible to that tick's decision. It is seen on the next tick.

## Configuration
- Macro: `ELEVADOR_EMERGENCIA_EN`.
- **Defined:**
  - Adds input `emergencia` (1 bit) and output `alarme` (1 bit, reset 0).
  - While `emergencia` = 1: the FSM is held in its current state and ticks are ignored. `pendentes` is cleared and new calls are discarded. `porta_aberta` is forced to 0 and `alarme` = 1.
  - On release, the FSM goes to PARADO on the next cycle. `andar_atual` is kept.
- **Undefined:** neither port exists and behaviour is as above.

## Structure
- Package `elevador_pkg`:
  - State enum `estado_t` (PARADO, SUBINDO, DESCENDO, PORTA).
  - Function/constant for floor width `LARG_ANDAR` = `$clog2(N_ANDARES)`.
  - Direction encoding constants.
- Sub-module `sincronizador_pulso`: 2-flop synchroniser plus rising-edge detector. Input `clock`, `reset`, async input; output `tick`.
- The FSM, call register and door timer live in `controlador_elevador`.

## Test plan
All scenarios use `N_ANDARES` = 4 and `TEMPO_PORTA` = 3.
- **Reset.** Reset low for 2 cycles → all outputs 0, state PARADO; `tick`s with no calls → no change.
- **Call to floor 2 from floor 0.** Tick 1 → `subindo` = 1. Tick 2 → `andar_atual` = 1. Tick 3 → `andar_atual` = 2, `porta_aberta` = 1, `pendentes[2]` = 0. Tick 6 → PARADO.
- **Call behind the car.** Car at floor 3 with door open; calls to floors 1 and 0 → DESCENDO. Stops at 1 (door 3 ticks), continues to 0. `pendentes` returns to 0.
- **Opposite calls while parked.** Car parked at floor 1 after going up; calls to floors 3 and 0 on the same cycle → goes up first (`ultimo_sentido`), then down.
- **Door reload and bound.** Car at floor 0 with door open; press floor 0 again → timer reloads, door stays 3 more ticks, `pendentes[0]` stays 0. No `andar_atual` underflow.
- **Reset mid-motion.** Reset low while SUBINDO at floor 1 → next edge: `andar_atual` = 0, `pendentes` = 0, `subindo` = 0.

Source files
------------

// File: rtl/controlador_elevador_pkg.sv
// Shared types and helpers for the elevator controller: FSM states, direction codes, floor width.
// Latency: none (declarations only).
// Backpressure: none.
package elevador_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    SUBINDO  = 2'd1,
    DESCENDO = 2'd2,
    PORTA    = 2'd3
  } estado_t;

  // Encoding of the remembered travel direction
  localparam logic SENTIDO_SOBE  = 1'b1;
  localparam logic SENTIDO_DESCE = 1'b0;

  localparam int N_ANDARES_PADRAO = 4;
  localparam int LARG_ANDAR       = $clog2(N_ANDARES_PADRAO);

  // Width of a counter able to address n distinct values (never less than 1 bit)
  function automatic int larg_andar(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/controlador_elevador_if.sv
// Elevator controller bus: slow clock and call buttons in, floor/lamps/door/pending calls out.
// Latency: wires only.
// Backpressure: none; emergencia/alarme exist only with ELEVADOR_EMERGENCIA_EN defined.
interface controlador_elevador_if #(
  parameter int N_ANDARES = 4
) ();

  logic                                          pulso_lento;
  logic [N_ANDARES-1:0]                          chamadas;
  logic [elevador_pkg::larg_andar(N_ANDARES)-1:0] andar_atual;
  logic                                          subindo;
  logic                                          descendo;
  logic                                          porta_aberta;
  logic [N_ANDARES-1:0]                          pendentes;
`ifdef ELEVADOR_EMERGENCIA_EN
  logic                                          emergencia;
  logic                                          alarme;
`endif

  modport master (
    output pulso_lento,
    output chamadas,
    input  andar_atual,
    input  subindo,
    input  descendo,
    input  porta_aberta,
    input  pendentes
`ifdef ELEVADOR_EMERGENCIA_EN
    ,
    output emergencia,
    input  alarme
`endif
  );

  modport slave (
    input  pulso_lento,
    input  chamadas,
    output andar_atual,
    output subindo,
    output descendo,
    output porta_aberta,
    output pendentes
`ifdef ELEVADOR_EMERGENCIA_EN
    ,
    input  emergencia,
    output alarme
`endif
  );

endinterface

// File: rtl/sincronizador_pulso.sv
// Brings the asynchronous slow clock into the board clock domain and emits a one-cycle tick per rising edge.
// Latency: tick is high in the cycle after the 2nd rising clock edge following the input rise.
// Backpressure: none; one tick per input edge, edges closer than the sync depth merge.
module sincronizador_pulso (
  input  logic clock,
  input  logic reset,
  input  logic pulso_lento,
  output logic tick
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Two-flop synchroniser followed by a history flop for edge detection
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pulso_lento;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign tick = r_s2 & ~r_s3;

endmodule

// File: rtl/controlador_elevador.sv
// Elevator car controller: latches floor calls and moves the car one floor per slow-clock tick, opening the door at called floors.
// Latency: state updates on the 3rd board-clock edge after pulso_lento rises; calls visible in pendentes one cycle after they rise.
// Backpressure: none; calls are sticky bits, optional ELEVADOR_EMERGENCIA_EN adds an emergency hold.
module controlador_elevador
  import elevador_pkg::*;
#(
  parameter int N_ANDARES   = 4,
  parameter int TEMPO_PORTA = 3
) (
  input logic                   clock,
  input logic                   reset,
  controlador_elevador_if.slave bus
);

  localparam int              LA          = larg_andar(N_ANDARES);
  localparam int              LT          = larg_andar(TEMPO_PORTA + 1);
  localparam logic [LA-1:0]   ANDAR_MAX   = LA'(N_ANDARES - 1);
  localparam logic [LT-1:0]   CARGA_PORTA = LT'(TEMPO_PORTA);

  estado_t              r_estado;
  logic [LA-1:0]        r_andar;
  logic [N_ANDARES-1:0] r_pend;
  logic [LT-1:0]        r_timer;
  logic                 r_sentido;

  logic                 w_tick;
  logic                 w_tick_ef;
  logic                 w_emerg;
  logic                 w_libera;
  logic                 w_acima;
  logic                 w_abaixo;
  logic                 w_pend_atual;
  logic                 w_chamada_atual;
  logic                 w_entra_porta;
  logic [LA-1:0]        w_andar_cima;
  logic [LA-1:0]        w_andar_baixo;
  logic [LA-1:0]        w_andar_alvo;
  logic [N_ANDARES-1:0] w_mascara;
  logic [N_ANDARES-1:0] w_limpa;

  sincronizador_pulso u_sinc (
    .clock       (clock),
    .reset       (reset),
    .pulso_lento (bus.pulso_lento),
    .tick        (w_tick)
  );

`ifdef ELEVADOR_EMERGENCIA_EN
  logic r_alarme;

  // Alarm follows the emergency input one cycle late; its falling side marks the release cycle
  always_ff @(posedge clock) begin
    if (!reset) r_alarme <= 1'b0;
    else        r_alarme <= bus.emergencia;
  end

  assign w_emerg          = bus.emergencia;
  assign w_libera         = r_alarme & ~bus.emergencia;
  assign bus.alarme       = r_alarme;
  assign bus.porta_aberta = (r_estado == PORTA) & ~r_alarme;
`else
  assign w_emerg          = 1'b0;
  assign w_libera         = 1'b0;
  assign bus.porta_aberta = (r_estado == PORTA);
`endif

  assign w_tick_ef       = w_tick & ~w_emerg;
  assign w_andar_cima    = r_andar + LA'(1);
  assign w_andar_baixo   = r_andar - LA'(1);
  assign w_pend_atual    = r_pend[r_andar];
  assign w_chamada_atual = bus.chamadas[r_andar];

  // Are there pending calls strictly above / below the car?
  always_comb begin
    w_acima  = 1'b0;
    w_abaixo = 1'b0;
    for (int i = 0; i < N_ANDARES; i++) begin
      if (r_pend[i] && (i > int'(r_andar))) w_acima  = 1'b1;
      if (r_pend[i] && (i < int'(r_andar))) w_abaixo = 1'b1;
    end
  end

  // Decide whether this tick opens the door, and at which floor
  always_comb begin
    w_entra_porta = 1'b0;
    w_andar_alvo  = r_andar;
    if (w_tick_ef) begin
      case (r_estado)
        PARADO:   w_entra_porta = w_pend_atual;
        SUBINDO: begin
          w_andar_alvo  = w_andar_cima;
          w_entra_porta = (r_andar != ANDAR_MAX) && r_pend[w_andar_cima];
        end
        DESCENDO: begin
          w_andar_alvo  = w_andar_baixo;
          w_entra_porta = (r_andar != '0) && r_pend[w_andar_baixo];
        end
        default:  w_entra_porta = 1'b0;
      endcase
    end
  end

  // Current-floor calls are swallowed while the door is open; the floor being opened is cleared
  always_comb begin
    w_mascara = bus.chamadas;
    if (r_estado == PORTA) w_mascara[r_andar] = 1'b0;
    w_limpa = '0;
    if (w_entra_porta) w_limpa[w_andar_alvo] = 1'b1;
  end

  // Main FSM: call register, floor counter, door timer and direction memory
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado  <= PARADO;
      r_andar   <= '0;
      r_pend    <= '0;
      r_timer   <= '0;
      r_sentido <= SENTIDO_SOBE;
    end else if (w_emerg) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend | w_mascara) & ~w_limpa;
      if (w_libera) begin
        r_estado <= PARADO;
      end else begin
        case (r_estado)
          PARADO: if (w_tick_ef) begin
            if (w_pend_atual) begin
              r_estado <= PORTA;
              r_timer  <= CARGA_PORTA;
            end else if (w_acima && w_abaixo) begin
              r_estado <= (r_sentido == SENTIDO_SOBE) ? SUBINDO : DESCENDO;
            end else if (w_acima) begin
              r_estado <= SUBINDO;
            end else if (w_abaixo) begin
              r_estado <= DESCENDO;
            end
          end
          SUBINDO: if (w_tick_ef) begin
            r_sentido <= SENTIDO_SOBE;
            if (r_andar == ANDAR_MAX) begin
              r_estado <= PARADO;
            end else begin
              r_andar <= w_andar_cima;
              if (w_entra_porta) begin
                r_estado <= PORTA;
                r_timer  <= CARGA_PORTA;
              end
            end
          end
          DESCENDO: if (w_tick_ef) begin
            r_sentido <= SENTIDO_DESCE;
            if (r_andar == '0) begin
              r_estado <= PARADO;
            end else begin
              r_andar <= w_andar_baixo;
              if (w_entra_porta) begin
                r_estado <= PORTA;
                r_timer  <= CARGA_PORTA;
              end
            end
          end
          PORTA: begin
            if (w_chamada_atual) begin
              r_timer <= CARGA_PORTA;
            end else if (w_tick_ef) begin
              if (r_timer == LT'(1)) begin
                if (r_sentido == SENTIDO_SOBE)
                  r_estado <= w_acima ? SUBINDO : (w_abaixo ? DESCENDO : PARADO);
                else
                  r_estado <= w_abaixo ? DESCENDO : (w_acima ? SUBINDO : PARADO);
              end else begin
                r_timer <= r_timer - LT'(1);
              end
            end
          end
          default: r_estado <= PARADO;
        endcase
      end
    end
  end

  assign bus.andar_atual = r_andar;
  assign bus.subindo     = (r_estado == SUBINDO);
  assign bus.descendo    = (r_estado == DESCENDO);
  assign bus.pendentes   = r_pend;

endmodule

// File: tb/tb_controlador_elevador.sv
// Self-checking bench for controlador_elevador with 4 floors and a 3-tick door.
// Latency: each vector waits out the full slow-clock edge before comparing.
// Backpressure: none.
module tb_controlador_elevador;

  typedef struct packed {
    logic [3:0] cham;
    logic [1:0] andar;
    logic       sub;
    logic       desc;
    logic       porta;
    logic [3:0] pend;
  } vetor_t;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  vetor_t tab[$];
  vetor_t fila[$];

  controlador_elevador_if #(.N_ANDARES(4)) bus ();

  controlador_elevador #(
    .N_ANDARES   (4),
    .TEMPO_PORTA (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checa(input string nome, input int atual, input int esp);
    checks++;
    if (atual != esp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esp);
    end
  endtask

  task automatic add(input logic [3:0] c, input logic [1:0] a, input logic s,
                     input logic d, input logic p, input logic [3:0] pe);
    vetor_t v;
    v.cham = c; v.andar = a; v.sub = s; v.desc = d; v.porta = p; v.pend = pe;
    tab.push_back(v);
  endtask

  // One-cycle call button press
  task automatic chamar(input logic [3:0] m);
    @(negedge clock) bus.chamadas = m;
    @(negedge clock) bus.chamadas = 4'b0000;
  endtask

  // One full slow-clock period; returns with the tick's update already applied
  task automatic pulso();
    @(negedge clock) bus.pulso_lento = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock) bus.pulso_lento = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic compara(input int idx);
    vetor_t e;
    e = fila.pop_front();
    checa($sformatf("r%0d andar", idx), int'(bus.andar_atual), int'(e.andar));
    checa($sformatf("r%0d subindo", idx), int'(bus.subindo), int'(e.sub));
    checa($sformatf("r%0d descendo", idx), int'(bus.descendo), int'(e.desc));
    checa($sformatf("r%0d porta", idx), int'(bus.porta_aberta), int'(e.porta));
    checa($sformatf("r%0d pendentes", idx), int'(bus.pendentes), int'(e.pend));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.pulso_lento = 1'b0;
    bus.chamadas = 4'b0000;
`ifdef ELEVADOR_EMERGENCIA_EN
    bus.emergencia = 1'b0;
`endif

    //    cham     andar sub desc porta pend
    add(4'b0000, 2'd0, 0, 0, 0, 4'b0000); // idle tick, nothing moves
    add(4'b0100, 2'd0, 1, 0, 0, 4'b0100); // call to 2 -> start up
    add(4'b0000, 2'd1, 1, 0, 0, 4'b0100);
    add(4'b0000, 2'd2, 0, 0, 1, 4'b0000); // arrive, door opens, bit cleared
    add(4'b0000, 2'd2, 0, 0, 1, 4'b0000);
    add(4'b0000, 2'd2, 0, 0, 1, 4'b0000);
    add(4'b0000, 2'd2, 0, 0, 0, 4'b0000); // door closes -> PARADO
    add(4'b1000, 2'd2, 1, 0, 0, 4'b1000); // call to top floor
    add(4'b0000, 2'd3, 0, 0, 1, 4'b0000);
    add(4'b0011, 2'd3, 0, 0, 1, 4'b0011); // calls behind the car
    add(4'b0000, 2'd3, 0, 0, 1, 4'b0011);
    add(4'b0000, 2'd3, 0, 1, 0, 4'b0011); // reverse
    add(4'b0000, 2'd2, 0, 1, 0, 4'b0011);
    add(4'b0000, 2'd1, 0, 0, 1, 4'b0001); // stop at 1
    add(4'b0000, 2'd1, 0, 0, 1, 4'b0001);
    add(4'b0000, 2'd1, 0, 0, 1, 4'b0001);
    add(4'b0000, 2'd1, 0, 1, 0, 4'b0001); // continue down
    add(4'b0000, 2'd0, 0, 0, 1, 4'b0000); // stop at 0
    add(4'b0000, 2'd0, 0, 0, 1, 4'b0000);
    add(4'b0001, 2'd0, 0, 0, 1, 4'b0000); // same-floor press reloads timer
    add(4'b0000, 2'd0, 0, 0, 1, 4'b0000); // still open thanks to reload
    add(4'b0000, 2'd0, 0, 0, 0, 4'b0000); // closes, no underflow
    add(4'b0010, 2'd0, 1, 0, 0, 4'b0010); // park at 1 after going up
    add(4'b0000, 2'd1, 0, 0, 1, 4'b0000);
    add(4'b0000, 2'd1, 0, 0, 1, 4'b0000);
    add(4'b0000, 2'd1, 0, 0, 1, 4'b0000);
    add(4'b0000, 2'd1, 0, 0, 0, 4'b0000);
    add(4'b1001, 2'd1, 1, 0, 0, 4'b1001); // opposite calls -> last direction (up)
    add(4'b0000, 2'd2, 1, 0, 0, 4'b1001);
    add(4'b0000, 2'd3, 0, 0, 1, 4'b0001);
    add(4'b0000, 2'd3, 0, 0, 1, 4'b0001);
    add(4'b0000, 2'd3, 0, 0, 1, 4'b0001);
    add(4'b0000, 2'd3, 0, 1, 0, 4'b0001); // then down
    add(4'b0000, 2'd2, 0, 1, 0, 4'b0001);
    add(4'b0000, 2'd1, 0, 1, 0, 4'b0001);
    add(4'b0000, 2'd0, 0, 0, 1, 4'b0000);
    add(4'b0000, 2'd0, 0, 0, 1, 4'b0000);
    add(4'b0000, 2'd0, 0, 0, 1, 4'b0000);
    add(4'b0000, 2'd0, 0, 0, 0, 4'b0000);

    // Reset for two cycles, then check reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    checa("reset andar", int'(bus.andar_atual), 0);
    checa("reset subindo", int'(bus.subindo), 0);
    checa("reset descendo", int'(bus.descendo), 0);
    checa("reset porta", int'(bus.porta_aberta), 0);
    checa("reset pendentes", int'(bus.pendentes), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].cham != 4'b0000) chamar(tab[i].cham);
      fila.push_back(tab[i]);
      pulso();
      compara(i);
    end

    // Call visibility is one cycle; tick lands on the 3rd edge
    @(negedge clock) bus.chamadas = 4'b0100;
    @(negedge clock) bus.chamadas = 4'b0000;
    checa("pend latency", int'(bus.pendentes), 4);
    @(negedge clock) bus.pulso_lento = 1'b1;
    repeat (2) @(posedge clock);
    #1 checa("tick edge2 no update", int'(bus.subindo), 0);
    @(posedge clock);
    #1 checa("tick edge3 update", int'(bus.subindo), 1);
    @(negedge clock) bus.pulso_lento = 1'b0;
    repeat (3) @(negedge clock);
    pulso();
    checa("moving andar", int'(bus.andar_atual), 1);

    // Reset while moving aborts on the next edge
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1;
    checa("midreset andar", int'(bus.andar_atual), 0);
    checa("midreset pendentes", int'(bus.pendentes), 0);
    checa("midreset subindo", int'(bus.subindo), 0);
    @(negedge clock) reset = 1'b1;
    repeat (2) @(negedge clock);

    // Call arriving in the tick cycle is only seen by the following tick
    @(negedge clock) bus.pulso_lento = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock) bus.chamadas = 4'b0010;
    @(negedge clock) bus.chamadas = 4'b0000;
    checa("sametick subindo", int'(bus.subindo), 0);
    checa("sametick pendentes", int'(bus.pendentes), 2);
    bus.pulso_lento = 1'b0;
    repeat (3) @(negedge clock);
    pulso();
    checa("nexttick subindo", int'(bus.subindo), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
